rs_issue_queue: RTL and testbench
=================================

# rs_issue_queue

Parametrised reservation station that holds dispatched ALU-class instructions until their source operands are available, then issues the oldest ready entry to the execution unit. It sits between the decoder/register-file dispatch path and the ALU. It supports configurable depth and tag width, and `CDB_N` result-broadcast channels from the ALU, LSB and other producers. Compared with the previous station it adds oldest-first selection, same-cycle wakeup bypass at dispatch, a valid/ready issue handshake with backpressure, and a full flush.

## Interface
- `DEPTH`, 16: entry count, power of two, ≥2
- `ROB_W`, 4: ROB tag width
- `DATA_W`, 32: operand/imm/pc width
- `OP_W`, 6: opcode id width
- `CDB_N`, 2: number of broadcast channels
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `rdy` in 1: global enable; low freezes all state (rst/flush still act)
- `flush` in 1: ROB mispredict rollback; clears all entries
- `disp_valid` in 1: dispatch request
- `disp_ready` out 1: a free entry exists; dispatch accepted when `disp_valid & disp_ready`
- `disp_rob_id` in ROB_W; `disp_pc` in DATA_W; `disp_op` in OP_W; `disp_imm` in DATA_W
- `disp_rs1_rdy`, `disp_rs2_rdy` in 1: operand value valid
- `disp_rs1_val`, `disp_rs2_val` in DATA_W; `disp_rs1_tag`, `disp_rs2_tag` in ROB_W: producer tag when not ready
- `cdb_valid` in CDB_N; `cdb_tag` in CDB_N*ROB_W; `cdb_value` in CDB_N*DATA_W: channel c occupies slice c
- `iss_valid` out 1; `iss_ready` in 1: issue handshake
- `iss_op` out OP_W; `iss_pc`, `iss_rs1`, `iss_rs2`, `iss_imm` out DATA_W; `iss_rob_id` out ROB_W
- `count` out $clog2(DEPTH+1): occupied entries (excludes the output register)

## Operation
- Each entry holds: `valid`, `rob_id`, `pc`, `op`, `imm`, and per operand `rdy`/`val`/`tag`.
- `disp_ready` = any entry invalid, evaluated from registered state only. A slot freed this cycle is reusable next cycle.
- Dispatch writes the lowest-index free slot. For each non-ready operand, if any `cdb_valid[c]` has `cdb_tag[c]` == operand tag in the same cycle, the entry stores `rdy=1` with that value (bypass).
- Wakeup: for every valid entry and operand with `rdy=0` whose tag matches a valid channel, set `rdy=1` and capture the value. If several channels match, the lowest channel index wins.
- Age: a DEPTH×DEPTH matrix with `older[i][j]` = entry i dispatched before j. On dispatch to k, set `older[j][k]=valid[j]` for all j and clear row k. A freed entry's row and column are don't-care, masked by `valid`.
- Selection candidates: valid entries with both `rdy=1` from registered state. The pick is the candidate i such that no other candidate j has `older[j][i]`.
- The output register loads when `!iss_valid || iss_ready` and a candidate exists. The chosen entry is invalidated on that edge and `iss_valid`=1.
- If the output register can load and there is no candidate: `iss_valid`←0. Outputs hold stable while `iss_valid & !iss_ready`.
- `count` is incremented on dispatch and decremented on load into the output register. Both in one cycle leave it unchanged.
- `flush` or `rst`: all `valid`=0, age matrix cleared, `iss_valid`=0, `count`=0. Flush beats a simultaneous dispatch, wakeup or issue. Data outputs reset to 0.

## Timing
- Reset values: `iss_valid`=0, all `iss_*`=0, `count`=0, `disp_ready`=1.
- Dispatch with both operands ready at edge N → eligible at N+1 → `iss_valid` high after edge N+1. Minimum 2-cycle dispatch-to-issue.
- A CDB wakeup at edge N (in-station or bypass) → eligible after N → earliest `iss_valid` after N+1.
- Throughput: one issue per cycle while `iss_ready`=1; one dispatch per cycle.
- Full: `disp_ready`=0 with DEPTH valid entries. When the output register loads at edge N, `disp_ready`=1 after N.
- `rdy`=0: no state change; `disp_ready` is still driven combinationally. Upstream must not count a dispatch as accepted while `rdy`=0.
- Tag 0 is a legal tag. Only `cdb_valid` gates matches.

## Test plan
- Reset, then dispatch rob 3 (add, rs1=5, rs2=7 ready) with `iss_ready`=1 → `iss_valid` two edges later; `iss_rob_id`=3, `iss_rs1`=5, `iss_rs2`=7; `count` returns to 0.
- Dispatch rob 1 (rs1 tag 9 pending), then rob 2 (ready). Broadcast tag 9 value 0x55 on channel 1 → rob 2 issues first. Rob 1 issues next with `iss_rs1`=0x55.
- Age: fill slots so rob 8 (older) lands in a higher index than rob 9 (younger) via a freed slot. Wake both in the same cycle → rob 8 issues before rob 9.
- Dispatch rob 4 with rs2 tag 6 while channel 0 broadcasts tag 6 value 0xAB in the same cycle → entry issues with `iss_rs2`=0xAB; no further broadcast needed.
- Hold `iss_ready`=0 and dispatch DEPTH+1 ready instructions → `disp_ready`=0 after DEPTH+1 accepts (DEPTH entries plus the output register); `iss_*` stable. Raise `iss_ready` → `disp_ready`=1 next cycle.
- With 5 entries valid and `iss_valid`=1, assert `flush` together with `disp_valid` → next cycle `count`=0, `iss_valid`=0, and the dispatched instruction is dropped.

Source files
------------

// File: rtl/rs_issue_queue.sv
// rs_issue_queue
// Reservation station for ALU-class instructions. Dispatched instructions wait
// here until both source operands are available. Operands arrive either at
// dispatch, from a same-cycle CDB bypass, or from a later CDB wakeup. The
// oldest ready entry is moved into a registered issue stage. That stage uses a
// valid/ready handshake, so the ALU can apply backpressure.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes state (rst/flush still act)
//   flush             clears every entry and the issue register
//   disp_*            dispatch request (disp_valid/disp_ready handshake) and payload
//   cdb_*             CDB_N broadcast channels; channel c occupies slice c
//   iss_*             issue register (iss_valid/iss_ready handshake) and payload
//   count             occupied entries, excluding the issue register
module rs_issue_queue #(
    parameter int DEPTH  = 16,
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int CDB_N  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [ROB_W-1:0]            disp_rob_id,
    input  logic [DATA_W-1:0]           disp_pc,
    input  logic [OP_W-1:0]             disp_op,
    input  logic [DATA_W-1:0]           disp_imm,
    input  logic                        disp_rs1_rdy,
    input  logic                        disp_rs2_rdy,
    input  logic [DATA_W-1:0]           disp_rs1_val,
    input  logic [DATA_W-1:0]           disp_rs2_val,
    input  logic [ROB_W-1:0]            disp_rs1_tag,
    input  logic [ROB_W-1:0]            disp_rs2_tag,
    input  logic [CDB_N-1:0]            cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]      cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]     cdb_value,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [OP_W-1:0]             iss_op,
    output logic [DATA_W-1:0]           iss_pc,
    output logic [DATA_W-1:0]           iss_rs1,
    output logic [DATA_W-1:0]           iss_rs2,
    output logic [DATA_W-1:0]           iss_imm,
    output logic [ROB_W-1:0]            iss_rob_id,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entry storage
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  rs1_rdy;
    logic [DEPTH-1:0]  rs2_rdy;
    logic [ROB_W-1:0]  rob_id  [DEPTH];
    logic [DATA_W-1:0] pc      [DEPTH];
    logic [OP_W-1:0]   op      [DEPTH];
    logic [DATA_W-1:0] imm     [DEPTH];
    logic [DATA_W-1:0] rs1_val [DEPTH];
    logic [DATA_W-1:0] rs2_val [DEPTH];
    logic [ROB_W-1:0]  rs1_tag [DEPTH];
    logic [ROB_W-1:0]  rs2_tag [DEPTH];

    // older[i][j] = entry i was dispatched before entry j (meaningful only
    // while both entries are valid)
    logic [DEPTH-1:0]  older   [DEPTH];

    // CDB match results: bit DATA_W is the hit flag, low bits the value
    logic [DATA_W:0]   wk1 [DEPTH];
    logic [DATA_W:0]   wk2 [DEPTH];
    logic [DATA_W:0]   byp1;
    logic [DATA_W:0]   byp2;

    logic [DEPTH-1:0]  cand;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [IDX_W-1:0]  free_idx;
    logic              disp_fire;
    logic              load;

    // Lowest-numbered matching channel wins when several carry the same tag.
    function automatic logic [DATA_W:0] cdb_match(input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int unsigned c = 0; c < CDB_N; c++) begin
            if (!r[DATA_W] && cdb_valid[c] && (cdb_tag[c*ROB_W +: ROB_W] == tag)) begin
                r = {1'b1, cdb_value[c*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wk1[i] = cdb_match(rs1_tag[i]);
            wk2[i] = cdb_match(rs2_tag[i]);
        end
        byp1 = cdb_match(disp_rs1_tag);
        byp2 = cdb_match(disp_rs2_tag);
    end

    // Free-slot search and dispatch handshake use registered state only
    assign disp_ready = ~&valid;
    assign disp_fire  = disp_valid & disp_ready;

    always_comb begin : free_search
        logic found;
        found    = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid[i] && !found) begin
                found    = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Oldest-first pick: a candidate is chosen when no other candidate is
    // older than it. The age matrix is a total order over valid entries, so
    // exactly one candidate qualifies.
    always_comb begin : select
        logic blocked;
        blocked    = 1'b0;
        cand       = valid & rs1_rdy & rs2_rdy;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((j != i) && cand[j] && older[j][i]) begin
                    blocked = 1'b1;
                end
            end
            if (cand[i] && !blocked && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

    assign load = (!iss_valid || iss_ready) && pick_found;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
            iss_valid  <= 1'b0;
            iss_op     <= '0;
            iss_pc     <= '0;
            iss_rs1    <= '0;
            iss_rs2    <= '0;
            iss_imm    <= '0;
            iss_rob_id <= '0;
            count      <= '0;
        end else if (rdy) begin
            // Wakeup of resident entries
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid[i] && !rs1_rdy[i] && wk1[i][DATA_W]) begin
                    rs1_rdy[i] <= 1'b1;
                    rs1_val[i] <= wk1[i][DATA_W-1:0];
                end
                if (valid[i] && !rs2_rdy[i] && wk2[i][DATA_W]) begin
                    rs2_rdy[i] <= 1'b1;
                    rs2_val[i] <= wk2[i][DATA_W-1:0];
                end
            end

            // Issue register
            if (load) begin
                valid[pick_idx] <= 1'b0;
                iss_valid       <= 1'b1;
                iss_op          <= op[pick_idx];
                iss_pc          <= pc[pick_idx];
                iss_rs1         <= rs1_val[pick_idx];
                iss_rs2         <= rs2_val[pick_idx];
                iss_imm         <= imm[pick_idx];
                iss_rob_id      <= rob_id[pick_idx];
            end else if (!iss_valid || iss_ready) begin
                iss_valid <= 1'b0;
            end

            // Dispatch into the lowest free slot, with same-cycle CDB bypass.
            // The free slot is never the picked slot, because the picked slot is valid.
            if (disp_fire) begin
                valid[free_idx]  <= 1'b1;
                rob_id[free_idx] <= disp_rob_id;
                pc[free_idx]     <= disp_pc;
                op[free_idx]     <= disp_op;
                imm[free_idx]    <= disp_imm;
                rs1_tag[free_idx] <= disp_rs1_tag;
                rs2_tag[free_idx] <= disp_rs2_tag;
                if (disp_rs1_rdy) begin
                    rs1_rdy[free_idx] <= 1'b1;
                    rs1_val[free_idx] <= disp_rs1_val;
                end else begin
                    rs1_rdy[free_idx] <= byp1[DATA_W];
                    rs1_val[free_idx] <= byp1[DATA_W-1:0];
                end
                if (disp_rs2_rdy) begin
                    rs2_rdy[free_idx] <= 1'b1;
                    rs2_val[free_idx] <= disp_rs2_val;
                end else begin
                    rs2_rdy[free_idx] <= byp2[DATA_W];
                    rs2_val[free_idx] <= byp2[DATA_W-1:0];
                end
                older[free_idx] <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (j != free_idx) begin
                        older[j][free_idx] <= valid[j];
                    end
                end
            end

            count <= count + CNT_W'(disp_fire) - CNT_W'(load);
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue. Each test pushes the issues it
// expects onto a scoreboard queue. A monitor pops the queue and compares the
// payload on every accepted issue handshake.
module tb_rs_issue_queue;

    localparam int DEPTH  = 16;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int CDB_N  = 2;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       rdy;
    logic                       flush;
    logic                       disp_valid;
    logic                       disp_ready;
    logic [ROB_W-1:0]           disp_rob_id;
    logic [DATA_W-1:0]          disp_pc;
    logic [OP_W-1:0]            disp_op;
    logic [DATA_W-1:0]          disp_imm;
    logic                       disp_rs1_rdy;
    logic                       disp_rs2_rdy;
    logic [DATA_W-1:0]          disp_rs1_val;
    logic [DATA_W-1:0]          disp_rs2_val;
    logic [ROB_W-1:0]           disp_rs1_tag;
    logic [ROB_W-1:0]           disp_rs2_tag;
    logic [CDB_N-1:0]           cdb_valid;
    logic [CDB_N*ROB_W-1:0]     cdb_tag;
    logic [CDB_N*DATA_W-1:0]    cdb_value;
    logic                       iss_valid;
    logic                       iss_ready;
    logic [OP_W-1:0]            iss_op;
    logic [DATA_W-1:0]          iss_pc;
    logic [DATA_W-1:0]          iss_rs1;
    logic [DATA_W-1:0]          iss_rs2;
    logic [DATA_W-1:0]          iss_imm;
    logic [ROB_W-1:0]           iss_rob_id;
    logic [CNT_W-1:0]           count;

    rs_issue_queue #(
        .DEPTH  (DEPTH),
        .ROB_W  (ROB_W),
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .CDB_N  (CDB_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_rob_id  (disp_rob_id),
        .disp_pc      (disp_pc),
        .disp_op      (disp_op),
        .disp_imm     (disp_imm),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .disp_rs1_val (disp_rs1_val),
        .disp_rs2_val (disp_rs2_val),
        .disp_rs1_tag (disp_rs1_tag),
        .disp_rs2_tag (disp_rs2_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_op       (iss_op),
        .iss_pc       (iss_pc),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_imm      (iss_imm),
        .iss_rob_id   (iss_rob_id),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROB_W-1:0]  rob;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Payload conventions shared by stimulus and expectations
    function automatic logic [OP_W-1:0] op_of(input logic [ROB_W-1:0] rob);
        return OP_W'(rob) + 6'd1;
    endfunction
    function automatic logic [DATA_W-1:0] pc_of(input logic [ROB_W-1:0] rob);
        return 32'h1000 + (DATA_W'(rob) << 2);
    endfunction
    function automatic logic [DATA_W-1:0] imm_of(input logic [ROB_W-1:0] rob);
        return 32'hF000 + DATA_W'(rob);
    endfunction

    task automatic push_exp(input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] r1,
                            input logic [DATA_W-1:0] r2);
        exp_t e;
        e.rob = rob;
        e.op  = op_of(rob);
        e.pc  = pc_of(rob);
        e.rs1 = r1;
        e.rs2 = r2;
        e.imm = imm_of(rob);
        sb.push_back(e);
    endtask

    // Scoreboard monitor: an issue is accepted on the next edge when all of these hold here
    always @(negedge clk) begin
        if (!rst && !flush && rdy && iss_valid && iss_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL issue_unexpected: got rob %0d, expected no issue", iss_rob_id);
            end else begin
                mon_e = sb.pop_front();
                if ({iss_rob_id, iss_op, iss_pc, iss_rs1, iss_rs2, iss_imm} !==
                    {mon_e.rob, mon_e.op, mon_e.pc, mon_e.rs1, mon_e.rs2, mon_e.imm}) begin
                    tests_failed++;
                    $display("FAIL issue_payload: got rob %0d op %0h pc %0h rs1 %0h rs2 %0h imm %0h, expected rob %0d op %0h pc %0h rs1 %0h rs2 %0h imm %0h",
                             iss_rob_id, iss_op, iss_pc, iss_rs1, iss_rs2, iss_imm,
                             mon_e.rob, mon_e.op, mon_e.pc, mon_e.rs1, mon_e.rs2, mon_e.imm);
                end
            end
        end
    end

    // Drive one dispatch and hold it until the DUT accepts it (bounded).
    task automatic dispatch(input logic [ROB_W-1:0] rob,
                            input logic r1r, input logic [DATA_W-1:0] r1v, input logic [ROB_W-1:0] r1t,
                            input logic r2r, input logic [DATA_W-1:0] r2v, input logic [ROB_W-1:0] r2t);
        int budget;
        budget       = 0;
        disp_valid   = 1'b1;
        disp_rob_id  = rob;
        disp_op      = op_of(rob);
        disp_pc      = pc_of(rob);
        disp_imm     = imm_of(rob);
        disp_rs1_rdy = r1r;
        disp_rs1_val = r1v;
        disp_rs1_tag = r1t;
        disp_rs2_rdy = r2r;
        disp_rs2_val = r2v;
        disp_rs2_tag = r2t;
        while (!disp_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!disp_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL dispatch_timeout: got disp_ready 0 for rob %0d, expected 1", rob);
        end
        @(posedge clk); #1;
        disp_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 0;
        while ((sb.size() != 0 || iss_valid) && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        tests_run++;
        if (sb.size() != 0 || iss_valid) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d pending issues, iss_valid %0b; expected 0, 0",
                     name, sb.size(), iss_valid);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        disp_rob_id = '0; disp_pc = '0; disp_op = '0; disp_imm = '0;
        disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; disp_rs1_val = '0; disp_rs2_val = '0;
        disp_rs1_tag = '0; disp_rs2_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (iss_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_iss_valid: got %0b expected 0", iss_valid); end
        tests_run++;
        if ({iss_rob_id, iss_op, iss_pc, iss_rs1, iss_rs2, iss_imm} !== '0) begin
            tests_failed++; $display("FAIL reset_iss_data: got rob %0h rs1 %0h expected all 0", iss_rob_id, iss_rs1);
        end
        tests_run++;
        if (count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests_run++;
        if (disp_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_disp_ready: got %0b expected 1", disp_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        iss_ready = 1'b1;
        push_exp(4'd3, 32'd5, 32'd7);
        dispatch(4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        tests_run++;
        if (iss_valid !== 1'b0 || count !== CNT_W'(1)) begin
            tests_failed++; $display("FAIL basic_after_dispatch: got iss_valid %0b count %0d expected 0, 1", iss_valid, count);
        end
        @(posedge clk); #1;
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rob_id !== 4'd3 || count !== '0) begin
            tests_failed++; $display("FAIL basic_issue_latency: got iss_valid %0b rob %0d count %0d expected 1, 3, 0", iss_valid, iss_rob_id, count);
        end
        wait_drain("basic");
        tests_run++;
        if (count !== '0) begin tests_failed++; $display("FAIL basic_count_end: got %0d expected 0", count); end
    endtask

    task automatic test_wakeup();
        iss_ready = 1'b1;
        push_exp(4'd2, 32'h22, 32'h23);
        push_exp(4'd1, 32'h55, 32'h11);
        dispatch(4'd1, 1'b0, 32'hBAD, 4'd9, 1'b1, 32'h11, 4'd0);
        dispatch(4'd2, 1'b1, 32'h22, 4'd0, 1'b1, 32'h23, 4'd0);
        // channel 0 carries an unrelated tag; channel 1 wakes rob 1
        cdb_valid = 2'b11;
        cdb_tag   = {4'd9, 4'd3};
        cdb_value = {32'h55, 32'hDEAD};
        @(posedge clk); #1;
        cdb_valid = '0;
        wait_drain("wakeup");
    endtask

    task automatic test_age();
        iss_ready = 1'b1;
        push_exp(4'd5, 32'h50, 32'h51);
        push_exp(4'd8, 32'h88, 32'h81);
        push_exp(4'd9, 32'h91, 32'h99);
        // rob 5 -> slot 0 then issues; rob 8 -> slot 1; idle; rob 9 reuses slot 0
        dispatch(4'd5, 1'b1, 32'h50, 4'd0, 1'b1, 32'h51, 4'd0);
        dispatch(4'd8, 1'b0, 32'h0, 4'd12, 1'b1, 32'h81, 4'd0);
        @(posedge clk); #1;
        dispatch(4'd9, 1'b1, 32'h91, 4'd0, 1'b0, 32'h0, 4'd13);
        cdb_valid = 2'b11;
        cdb_tag   = {4'd12, 4'd13};
        cdb_value = {32'h88, 32'h99};
        @(posedge clk); #1;
        cdb_valid = '0;
        wait_drain("age");
    endtask

    task automatic test_bypass();
        iss_ready = 1'b1;
        push_exp(4'd4, 32'h44, 32'hAB);
        // both channels match tag 6; channel 0 must win
        cdb_valid = 2'b11;
        cdb_tag   = {4'd6, 4'd6};
        cdb_value = {32'hCD, 32'hAB};
        dispatch(4'd4, 1'b1, 32'h44, 4'd0, 1'b0, 32'h0, 4'd6);
        cdb_valid = '0;
        @(posedge clk); #1;
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rs2 !== 32'hAB) begin
            tests_failed++; $display("FAIL bypass_issue: got iss_valid %0b rs2 %0h expected 1, ab", iss_valid, iss_rs2);
        end
        wait_drain("bypass");
    endtask

    task automatic test_full();
        iss_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            push_exp(ROB_W'(i), 32'h100 + i, 32'h200 + i);
            dispatch(ROB_W'(i), 1'b1, 32'h100 + i, 4'd0, 1'b1, 32'h200 + i, 4'd0);
        end
        tests_run++;
        if (disp_ready !== 1'b0 || count !== CNT_W'(DEPTH)) begin
            tests_failed++; $display("FAIL full_state: got disp_ready %0b count %0d expected 0, %0d", disp_ready, count, DEPTH);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rob_id !== 4'd0 || iss_rs1 !== 32'h100 || iss_rs2 !== 32'h200) begin
            tests_failed++; $display("FAIL full_hold: got iss_valid %0b rob %0d rs1 %0h rs2 %0h expected 1, 0, 100, 200", iss_valid, iss_rob_id, iss_rs1, iss_rs2);
        end
        // rdy low freezes the station even with the consumer ready
        rdy = 1'b0;
        iss_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (iss_valid !== 1'b1 || iss_rob_id !== 4'd0 || count !== CNT_W'(DEPTH) || disp_ready !== 1'b0) begin
            tests_failed++; $display("FAIL rdy_freeze: got iss_valid %0b rob %0d count %0d disp_ready %0b expected 1, 0, %0d, 0", iss_valid, iss_rob_id, count, disp_ready, DEPTH);
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (disp_ready !== 1'b1 || count !== CNT_W'(DEPTH-1)) begin
            tests_failed++; $display("FAIL full_release: got disp_ready %0b count %0d expected 1, %0d", disp_ready, count, DEPTH-1);
        end
        wait_drain("full");
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dispatch(ROB_W'(10 + i), 1'b1, 32'h300 + i, 4'd0, 1'b1, 32'h400 + i, 4'd0);
        end
        tests_run++;
        if (count !== CNT_W'(5) || iss_valid !== 1'b1) begin
            tests_failed++; $display("FAIL flush_setup: got count %0d iss_valid %0b expected 5, 1", count, iss_valid);
        end
        flush        = 1'b1;
        disp_valid   = 1'b1;
        disp_rob_id  = 4'd7;
        disp_op      = op_of(4'd7);
        disp_pc      = pc_of(4'd7);
        disp_imm     = imm_of(4'd7);
        disp_rs1_rdy = 1'b1;
        disp_rs2_rdy = 1'b1;
        @(posedge clk); #1;
        flush      = 1'b0;
        disp_valid = 1'b0;
        tests_run++;
        if (count !== '0 || iss_valid !== 1'b0 || iss_rob_id !== '0 || disp_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_clear: got count %0d iss_valid %0b rob %0d disp_ready %0b expected 0, 0, 0, 1", count, iss_valid, iss_rob_id, disp_ready);
        end
        iss_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (iss_valid !== 1'b0 || count !== '0) begin
            tests_failed++; $display("FAIL flush_dropped: got iss_valid %0b count %0d expected 0, 0", iss_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_age();
        test_bypass();
        test_full();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
